// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
//   state_t      : loader FSM encoding
//   ACK_BYTE     : reply byte for a frame that loaded cleanly
//   NAK_BYTE     : reply byte for a bad length or checksum
//   is_intake()  : states in which bytes are popped from the rx FIFO
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHK,
    ST_ACK,
    ST_NAK,
    ST_RUN
  } state_t;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  function automatic logic is_intake(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_boot_loader_word_packer.sv
// boot_word_packer: assembles little-endian bytes into a 32-bit word.
//   clk       in   system clock
//   byte_vld  in   byte_in is accepted this cycle
//   byte_in   in   incoming byte
//   lane      in   byte lane 0..3 (lane 0 -> word[7:0])
//   word      out  held word with the current byte merged into its lane
//   done      out  byte_vld on lane 3: word is complete this cycle
// The merged word is combinational so the parent can register it into the
// RAM write port on the same edge that accepts the fourth byte.
module boot_word_packer (
  input  logic        clk,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  lane,
  output logic [31:0] word,
  output logic        done
);

  logic [31:0] word_p0;

  always_comb begin
    word = word_p0;
    case (lane)
      2'd0:    word[7:0]   = byte_in;
      2'd1:    word[15:8]  = byte_in;
      2'd2:    word[23:16] = byte_in;
      default: word[31:24] = byte_in;
    endcase
  end

  assign done = byte_vld && (lane == 2'd3);

  always_ff @(posedge clk) begin
    if (byte_vld) word_p0 <= word;
  end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program image over the UART, writes it to RAM
// and holds the CPU in reset until a frame with a good checksum has loaded.
// Frame: LEN_LO, LEN_HI (word count N), 4*N data bytes LE, CHK = XOR of data.
//   clk, reset           system clock, synchronous active-high reset
//   rx_empty, rx_data    rx FIFO status and head byte
//   rd_uart              rx FIFO pop pulse
//   tx_full              tx FIFO full
//   wr_uart, tx_data     tx FIFO push pulse and ACK/NAK byte
//   mem_addr/wdata/we    RAM word write port (we is 0 or 4'hF)
//   cpu_reset            holds the CPU in reset until the image is accepted
//   busy                 a frame is in progress
//   err                  sticky: a NAK has been sent since reset
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int          ADDR_W = 11,
  parameter logic [7:0]  ACK    = ACK_BYTE,
  parameter logic [7:0]  NAK    = NAK_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t      state, state_next;
  logic        take;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] n_full;
  logic [16:0] cnt;
  logic [1:0]  lane;
  logic [7:0]  chk;
  logic        last_word;
  logic [31:0] word_next;
  logic        word_done;

  // A pop is only issued when none went out last cycle, so rx_empty has had a
  // cycle to reflect the previous pop and a stale head is never taken twice.
  assign take      = is_intake(state) && !rx_empty && !rd_uart;
  assign n_full    = {rx_data, n_lo};
  // 17-bit compare so N = 2**ADDR_W terminates exactly.
  assign last_word = (cnt + 17'd1) == {1'b0, n_words};

  boot_word_packer u_packer (
    .clk      (clk),
    .byte_vld (take && (state == ST_DATA)),
    .byte_in  (rx_data),
    .lane     (lane),
    .word     (word_next),
    .done     (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LEN0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LEN0: if (take) state_next = ST_LEN1;
      ST_LEN1: begin
        if (take) begin
          if (n_full == 16'd0)                state_next = ST_CHK;
          else if ({1'b0, n_full} > MAX_WORDS) state_next = ST_NAK;
          else                                 state_next = ST_DATA;
        end
      end
      ST_DATA: if (word_done && last_word) state_next = ST_CHK;
      ST_CHK:  if (take) state_next = (rx_data == chk) ? ST_ACK : ST_NAK;
      ST_ACK:  if (!tx_full) state_next = ST_RUN;
      ST_NAK:  if (!tx_full) state_next = ST_LEN0;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_LEN0;
    endcase
  end

  // Stage p0: handshake, RAM strobe and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_uart   <= 1'b0;
      wr_uart   <= 1'b0;
      tx_data   <= 8'h00;
      mem_we    <= 4'h0;
      mem_addr  <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_uart <= take;
      wr_uart <= 1'b0;
      mem_we  <= 4'h0;
      if ((state == ST_LEN0) && take) busy <= 1'b1;
      if (word_done) begin
        mem_we   <= 4'hF;
        mem_addr <= cnt[ADDR_W-1:0];
      end
      if ((state == ST_ACK) && !tx_full) begin
        wr_uart <= 1'b1;
        tx_data <= ACK;
        busy    <= 1'b0;
      end
      if ((state == ST_NAK) && !tx_full) begin
        wr_uart <= 1'b1;
        tx_data <= NAK;
        err     <= 1'b1;
        busy    <= 1'b0;
      end
      if (state == ST_RUN) begin
        cpu_reset <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

  // Stage p0: frame datapath (initialised from the length bytes, no reset)
  always_ff @(posedge clk) begin
    if ((state == ST_LEN0) && take) n_lo <= rx_data;
    if ((state == ST_LEN1) && take) begin
      n_words <= n_full;
      cnt     <= '0;
      lane    <= 2'd0;
      chk     <= 8'h00;
    end
    if ((state == ST_DATA) && take) begin
      chk  <= chk ^ rx_data;
      lane <= lane + 2'd1;
      if (word_done) cnt <= cnt + 17'd1;
    end
    if (word_done) mem_wdata <= word_next;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: an rx FIFO model feeds frames,
// expected RAM writes and ACK/NAK bytes are queued as frames are built and
// compared as the DUT produces them.
module tb_uart_boot_loader;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_empty = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_full = 1'b0;
  logic              rd_uart;
  logic              wr_uart;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  logic              cpu_reset;
  logic              busy;
  logic              err;

  uart_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rd_uart   (rd_uart),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .tx_data   (tx_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [7:0]  rx_q[$];
  logic [42:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] img[$];
  int total = 0;
  int bad = 0;
  int we_cycles = 0;
  int tx_pulses = 0;
  logic rd_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rx FIFO model, RAM-write and tx scoreboards, all on the falling edge
  always @(negedge clk) begin
    if (rd_uart === 1'b1) begin
      check("rd_back_to_back", {63'd0, rd_prev}, 64'd0);
      check("rd_while_empty", {63'd0, rx_empty}, 64'd0);
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    rd_prev = rd_uart;
    if (mem_we !== 4'h0) begin
      we_cycles++;
      if (exp_wr.size() == 0)
        check("unexpected_write", {17'd0, mem_we, mem_addr, mem_wdata}, 64'd0);
      else
        check("mem_write", {17'd0, mem_we, mem_addr, mem_wdata}, {17'd0, 4'hF, exp_wr.pop_front()});
    end
    if (wr_uart === 1'b1) begin
      tx_pulses++;
      if (exp_tx.size() == 0)
        check("unexpected_tx", {56'd0, tx_data}, 64'd0);
      else
        check("tx_byte", {56'd0, tx_data}, {56'd0, exp_tx.pop_front()});
    end
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  task automatic put(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  // Queue a frame of n words from img; chk_flip != 0 corrupts the checksum.
  task automatic frame(input logic [15:0] n, input logic [7:0] chk_flip);
    logic [7:0] c;
    logic [31:0] w;
    c = 8'h00;
    put(n[7:0]);
    put(n[15:8]);
    if (32'(n) > (32'd1 << ADDR_W)) begin
      exp_tx.push_back(8'h15);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = img[i];
      for (int b = 0; b < 4; b++) begin
        put(w[8*b +: 8]);
        c = c ^ w[8*b +: 8];
      end
      exp_wr.push_back({11'(i), w});
    end
    put(c ^ chk_flip);
    exp_tx.push_back((chk_flip == 8'h00) ? 8'h06 : 8'h15);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_wr.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_tx_pending"}, 64'(exp_tx.size()), 64'd0);
    check({tag, "_wr_pending"}, 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs",
          {50'd0, rd_uart, wr_uart, tx_data, mem_we},
          {50'd0, 1'b0, 1'b0, 8'h00, 4'h0});
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_status", {61'd0, cpu_reset, busy, err}, {61'd0, 3'b100});
    reset = 1'b0;
  endtask

  int we0;
  int tx0;
  int held_bad;

  initial begin
    // 1: two-word frame with good checksum
    do_reset();
    img = '{32'h44332211, 32'h88776655};
    we0 = we_cycles;
    frame(16'd2, 8'h00);
    wait_done("t1", 400);
    check("t1_status", {61'd0, cpu_reset, busy, err}, {61'd0, 3'b000});
    check("t1_we_cycles", 64'(we_cycles - we0), 64'd2);

    // 2: bad checksum (0x00) then retry with the good frame
    do_reset();
    frame(16'd2, 8'h88);
    wait_done("t2a", 400);
    check("t2a_status", {61'd0, cpu_reset, busy, err}, {61'd0, 3'b101});
    frame(16'd2, 8'h00);
    wait_done("t2b", 400);
    check("t2b_status", {61'd0, cpu_reset, busy, err}, {61'd0, 3'b001});

    // 3: empty image
    do_reset();
    we0 = we_cycles;
    frame(16'd0, 8'h00);
    wait_done("t3", 100);
    check("t3_we_cycles", 64'(we_cycles - we0), 64'd0);
    check("t3_cpu_reset", {63'd0, cpu_reset}, 64'd0);

    // 4: oversize length, then the largest legal image
    do_reset();
    we0 = we_cycles;
    frame(16'h0801, 8'h00);
    wait_done("t4a", 100);
    check("t4a_we_cycles", 64'(we_cycles - we0), 64'd0);
    check("t4a_status", {61'd0, cpu_reset, busy, err}, {61'd0, 3'b101});
    img.delete();
    for (int i = 0; i < 2048; i++) img.push_back(32'hA5A5A5A5);
    we0 = we_cycles;
    frame(16'h0800, 8'h00);
    wait_done("t4b", 20000);
    check("t4b_we_cycles", 64'(we_cycles - we0), 64'd2048);
    check("t4b_last_addr", 64'(mem_addr), 64'h7FF);
    check("t4b_cpu_reset", {63'd0, cpu_reset}, 64'd0);

    // 5: tx FIFO full at the ACK point
    do_reset();
    img = '{32'hCAFEF00D};
    tx_full = 1'b1;
    frame(16'd1, 8'h00);
    for (int k = 0; k < 200 && (rx_q.size() != 0 || exp_wr.size() != 0); k++) @(posedge clk);
    repeat (5) @(posedge clk);
    held_bad = 0;
    tx0 = tx_pulses;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wr_uart !== 1'b0 || cpu_reset !== 1'b1) held_bad++;
    end
    check("t5_hold", 64'(held_bad), 64'd0);
    @(posedge clk);
    #1;
    tx_full = 1'b0;
    wait_done("t5", 100);
    check("t5_one_pulse", 64'(tx_pulses - tx0), 64'd1);
    check("t5_cpu_reset", {63'd0, cpu_reset}, 64'd0);

    // 6: reset after five data bytes, then a fresh one-word frame
    do_reset();
    put(8'h02); put(8'h00);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h55);
    exp_wr.push_back({11'd0, 32'h44332211});
    for (int k = 0; k < 200 && (rx_q.size() != 0 || exp_wr.size() != 0); k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("t6_busy_mid", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_after_reset", {59'd0, busy, mem_we}, 64'd0);
    img = '{32'hDDCCBBAA};
    we0 = we_cycles;
    frame(16'd1, 8'h00);
    wait_done("t6", 200);
    check("t6_we_cycles", 64'(we_cycles - we0), 64'd1);
    check("t6_status", {61'd0, cpu_reset, busy, err}, {61'd0, 3'b000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
